// File: rtl/channel_strip_pkg.sv
// rtl/channel_strip_pkg.sv - shared types and constants for the channel strip button selector
package channel_strip_pkg;

    typedef logic [2:0] sel_t;

    localparam int DEBOUNCE_CYCLES_DEFAULT = 1000000;

    localparam int FREQ_BIT     = 0;
    localparam int LOWPASS_BIT  = 1;
    localparam int HIGHPASS_BIT = 2;

    typedef enum logic [0:0] {
        HS_IDLE = 1'b0,
        HS_REQ  = 1'b1
    } hs_state_t;

endpackage

// File: rtl/button_select_ctrl_if.sv
// rtl/button_select_ctrl_if.sv - configuration update handshake toward the coefficient loader
interface button_select_ctrl_if;
    import channel_strip_pkg::*;

    logic cfgValid;
    sel_t cfgMask;
    logic cfgReady;

    modport master (output cfgValid, output cfgMask, input cfgReady);
    modport slave  (input cfgValid, input cfgMask, output cfgReady);
endinterface

// File: rtl/button_debounce.sv
// rtl/button_debounce.sv - 2-flop synchroniser plus whole-vector debounce
module button_debounce #(
    parameter int WIDTH           = 16,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] stable
);
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] candidate;
    logic [CW-1:0]    cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1     <= '0;
            sync2     <= '0;
            candidate <= '0;
            cnt       <= '0;
            stable    <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            if (sync2 != candidate) begin
                candidate <= sync2;
                cnt       <= '0;
            end else begin
                if (cnt != CNT_MAX)
                    cnt <= cnt + 1'b1;
                // Accept on the edge the counter arrives at its limit; saturated counts keep it.
                if (cnt == CNT_MAX || cnt + 1'b1 == CNT_MAX)
                    stable <= candidate;
            end
        end
    end
endmodule

// File: rtl/button_select_ctrl.sv
// rtl/button_select_ctrl.sv - decodes debounced one-hot presses into held selects and
// requests coefficient reloads through a valid/ready handshake
module button_select_ctrl
    import channel_strip_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [15:0]                 buttons,
    output sel_t                        freqSelect,
    output sel_t                        lowpassSelect,
    output sel_t                        highpassSelect,
    button_select_ctrl_if.master        cfg
);
    localparam logic [0:0] IDLE = HS_IDLE;
    localparam logic [0:0] REQ  = HS_REQ;

    logic [15:0] stable;
    logic [15:0] prev_stable;
    logic        press;
    logic [3:0]  idx;
    logic [2:0]  set_bits;
    logic [2:0]  dirty;
    logic [0:0]  state;
    sel_t        mask;

    button_debounce #(
        .WIDTH           (16),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk    (clk),
        .reset  (reset),
        .raw    (buttons),
        .stable (stable)
    );

    // Only a release-to-single-button transition counts; chords and slides are ignored.
    always_comb begin
        press    = (prev_stable == 16'h0000) && $onehot(stable);
        idx      = 4'd0;
        set_bits = 3'b000;
        for (int i = 0; i < 16; i++)
            if (stable[i])
                idx = 4'(i);
        if (press) begin
            if (!idx[3]) begin
                if (freqSelect != idx[2:0])
                    set_bits[FREQ_BIT] = 1'b1;
            end else if (!idx[2]) begin
                if (lowpassSelect != {1'b0, idx[1:0]})
                    set_bits[LOWPASS_BIT] = 1'b1;
            end else begin
                if (highpassSelect != {1'b0, idx[1:0]})
                    set_bits[HIGHPASS_BIT] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_stable    <= '0;
            freqSelect     <= '0;
            lowpassSelect  <= '0;
            highpassSelect <= '0;
        end else begin
            prev_stable <= stable;
            if (set_bits[FREQ_BIT])
                freqSelect <= idx[2:0];
            if (set_bits[LOWPASS_BIT])
                lowpassSelect <= {1'b0, idx[1:0]};
            if (set_bits[HIGHPASS_BIT])
                highpassSelect <= {1'b0, idx[1:0]};
        end
    end

    // Capturing dirty clears only the captured bits; same-cycle new bits are kept.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            mask  <= '0;
            dirty <= 3'b111;
        end else begin
            case (state)
                IDLE: begin
                    if (dirty != 3'b000) begin
                        state <= REQ;
                        mask  <= dirty;
                        dirty <= set_bits;
                    end else begin
                        dirty <= set_bits;
                    end
                end
                default: begin
                    if (cfg.cfgReady) begin
                        if (dirty != 3'b000) begin
                            mask  <= dirty;
                            dirty <= set_bits;
                        end else begin
                            state <= IDLE;
                            mask  <= '0;
                            dirty <= set_bits;
                        end
                    end else begin
                        dirty <= dirty | set_bits;
                    end
                end
            endcase
        end
    end

    assign cfg.cfgValid = (state == REQ);
    assign cfg.cfgMask  = mask;
endmodule

// File: tb/tb_button_select_ctrl.sv
// tb/tb_button_select_ctrl.sv - directed self-checking bench for button_select_ctrl
module tb_button_select_ctrl;
    import channel_strip_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] buttons = 16'h0000;
    sel_t        freqSelect, lowpassSelect, highpassSelect;
    int          vectors = 0;
    int          miscompares = 0;

    button_select_ctrl_if cfg_if ();

    button_select_ctrl #(.DEBOUNCE_CYCLES(8)) dut (
        .clk            (clk),
        .reset          (reset),
        .buttons        (buttons),
        .freqSelect     (freqSelect),
        .lowpassSelect  (lowpassSelect),
        .highpassSelect (highpassSelect),
        .cfg            (cfg_if.master)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        cfg_if.cfgReady = 1'b1;
        buttons = 16'h0000;
        reset = 1'b1;
        tick();
        tick();
        vectors++;
        if (cfg_if.cfgValid !== 1'b0 || cfg_if.cfgMask !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_hold: valid=%b mask=%b, want valid=0 mask=000", cfg_if.cfgValid, cfg_if.cfgMask);
        end
        reset = 1'b0;
        tick();
        vectors++;
        if (cfg_if.cfgValid !== 1'b1 || cfg_if.cfgMask !== 3'b111) begin
            miscompares++;
            $display("FAIL reset_req: valid=%b mask=%b, want valid=1 mask=111", cfg_if.cfgValid, cfg_if.cfgMask);
        end
        vectors++;
        if (freqSelect !== 3'd0 || lowpassSelect !== 3'd0 || highpassSelect !== 3'd0) begin
            miscompares++;
            $display("FAIL reset_selects: f=%0d l=%0d h=%0d, want 0 0 0", freqSelect, lowpassSelect, highpassSelect);
        end
        tick();
        vectors++;
        if (cfg_if.cfgValid !== 1'b0 || cfg_if.cfgMask !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_done: valid=%b mask=%b, want valid=0 mask=000", cfg_if.cfgValid, cfg_if.cfgMask);
        end
    endtask

    task automatic test_freq_press();
        buttons = 16'h0020;
        repeat (10) tick();
        vectors++;
        if (freqSelect !== 3'd0) begin
            miscompares++;
            $display("FAIL freq_early: freqSelect=%0d after 10 edges, want 0", freqSelect);
        end
        tick();
        vectors++;
        if (freqSelect !== 3'd5) begin
            miscompares++;
            $display("FAIL freq_latency: freqSelect=%0d after 11 edges, want 5", freqSelect);
        end
        tick();
        vectors++;
        if (cfg_if.cfgValid !== 1'b1 || cfg_if.cfgMask !== 3'b001) begin
            miscompares++;
            $display("FAIL freq_req: valid=%b mask=%b, want valid=1 mask=001", cfg_if.cfgValid, cfg_if.cfgMask);
        end
        tick();
        vectors++;
        if (cfg_if.cfgValid !== 1'b0) begin
            miscompares++;
            $display("FAIL freq_req_done: valid=%b, want 0", cfg_if.cfgValid);
        end
        repeat (8) tick();
        buttons = 16'h0000;
        repeat (20) tick();
        vectors++;
        if (freqSelect !== 3'd5 || cfg_if.cfgValid !== 1'b0) begin
            miscompares++;
            $display("FAIL freq_release: freqSelect=%0d valid=%b, want 5 and 0", freqSelect, cfg_if.cfgValid);
        end
    endtask

    task automatic test_bounce();
        for (int c = 0; c < 40; c++) begin
            if (c % 4 == 0)
                buttons = buttons ^ 16'h0200;
            tick();
            vectors++;
            if (cfg_if.cfgValid !== 1'b0 || lowpassSelect !== 3'd0) begin
                miscompares++;
                $display("FAIL bounce_cycle%0d: valid=%b lowpass=%0d, want 0 0", c, cfg_if.cfgValid, lowpassSelect);
            end
        end
        buttons = 16'h0000;
        repeat (20) tick();
        vectors++;
        if (lowpassSelect !== 3'd0 || freqSelect !== 3'd5 || cfg_if.cfgValid !== 1'b0) begin
            miscompares++;
            $display("FAIL bounce_final: lowpass=%0d freq=%0d valid=%b, want 0 5 0", lowpassSelect, freqSelect, cfg_if.cfgValid);
        end
    endtask

    task automatic test_chord_and_same();
        buttons = 16'h0101;
        for (int c = 0; c < 20; c++) begin
            tick();
            vectors++;
            if (cfg_if.cfgValid !== 1'b0) begin
                miscompares++;
                $display("FAIL chord_cycle%0d: valid=%b, want 0", c, cfg_if.cfgValid);
            end
        end
        buttons = 16'h0000;
        repeat (20) tick();
        buttons = 16'h0020;
        for (int c = 0; c < 20; c++) begin
            tick();
            vectors++;
            if (cfg_if.cfgValid !== 1'b0) begin
                miscompares++;
                $display("FAIL same_cycle%0d: valid=%b, want 0", c, cfg_if.cfgValid);
            end
        end
        buttons = 16'h0000;
        repeat (20) tick();
        vectors++;
        if (freqSelect !== 3'd5 || lowpassSelect !== 3'd0 || highpassSelect !== 3'd0) begin
            miscompares++;
            $display("FAIL chord_selects: f=%0d l=%0d h=%0d, want 5 0 0", freqSelect, lowpassSelect, highpassSelect);
        end
    endtask

    task automatic test_back_to_back();
        cfg_if.cfgReady = 1'b0;
        buttons = 16'h2000;
        repeat (11) tick();
        vectors++;
        if (highpassSelect !== 3'd1) begin
            miscompares++;
            $display("FAIL b2b_highpass: highpassSelect=%0d, want 1", highpassSelect);
        end
        tick();
        vectors++;
        if (cfg_if.cfgValid !== 1'b1 || cfg_if.cfgMask !== 3'b100) begin
            miscompares++;
            $display("FAIL b2b_first_req: valid=%b mask=%b, want 1 100", cfg_if.cfgValid, cfg_if.cfgMask);
        end
        buttons = 16'h0000;
        repeat (12) tick();
        buttons = 16'h0004;
        repeat (11) tick();
        vectors++;
        if (freqSelect !== 3'd2 || cfg_if.cfgMask !== 3'b100 || cfg_if.cfgValid !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_hold: freq=%0d valid=%b mask=%b, want 2 1 100", freqSelect, cfg_if.cfgValid, cfg_if.cfgMask);
        end
        tick();
        vectors++;
        if (cfg_if.cfgMask !== 3'b100) begin
            miscompares++;
            $display("FAIL b2b_mask_stable: mask=%b, want 100", cfg_if.cfgMask);
        end
        cfg_if.cfgReady = 1'b1;
        tick();
        vectors++;
        if (cfg_if.cfgValid !== 1'b1 || cfg_if.cfgMask !== 3'b001) begin
            miscompares++;
            $display("FAIL b2b_second_req: valid=%b mask=%b, want 1 001", cfg_if.cfgValid, cfg_if.cfgMask);
        end
        tick();
        vectors++;
        if (cfg_if.cfgValid !== 1'b0 || highpassSelect !== 3'd1 || freqSelect !== 3'd2) begin
            miscompares++;
            $display("FAIL b2b_done: valid=%b h=%0d f=%0d, want 0 1 2", cfg_if.cfgValid, highpassSelect, freqSelect);
        end
        buttons = 16'h0000;
        repeat (20) tick();
    endtask

    task automatic test_reset_mid_debounce();
        cfg_if.cfgReady = 1'b1;
        buttons = 16'h0800;
        repeat (4) tick();
        reset = 1'b1;
        #1;
        vectors++;
        if (freqSelect !== 3'd0 || lowpassSelect !== 3'd0 || highpassSelect !== 3'd0 ||
            cfg_if.cfgValid !== 1'b0 || cfg_if.cfgMask !== 3'b000) begin
            miscompares++;
            $display("FAIL async_reset: f=%0d l=%0d h=%0d valid=%b mask=%b, want all 0",
                     freqSelect, lowpassSelect, highpassSelect, cfg_if.cfgValid, cfg_if.cfgMask);
        end
        buttons = 16'h0000;
        repeat (2) tick();
        reset = 1'b0;
        for (int c = 0; c < 30; c++) begin
            tick();
            vectors++;
            if (lowpassSelect === 3'd3) begin
                miscompares++;
                $display("FAIL reset_discard_cycle%0d: lowpass=%0d, want not 3", c, lowpassSelect);
            end
        end
        vectors++;
        if (lowpassSelect !== 3'd0 || cfg_if.cfgValid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_discard_final: lowpass=%0d valid=%b, want 0 0", lowpassSelect, cfg_if.cfgValid);
        end
    endtask

    initial begin
        cfg_if.cfgReady = 1'b1;
        test_reset();
        test_freq_press();
        test_bounce();
        test_chord_and_same();
        test_back_to_back();
        test_reset_mid_debounce();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/button_select_ctrl.md
BUTTON_SELECT_CTRL -- requirements
Module: button_select_ctrl

Interface
REQ-001 SHALL use one clock; reset is asynchronous and active-high.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 1000000 (20 ms at 50 MHz): the number of consecutive clocks a synchronised button vector must hold before it is accepted.
REQ-003 SHALL have port clk, input, 1: system clock, rising-edge.
REQ-004 SHALL have port reset, input, 1: asynchronous active-high reset.
REQ-005 SHALL have port buttons, input, 16: raw, asynchronous, active-high panel buttons.
REQ-006 SHALL have port freqSelect, output, 3: held EQ frequency index, 0-7.
REQ-007 SHALL have port lowpassSelect, output, 3: held lowpass index, 0-3; bit 2 is always 0.
REQ-008 SHALL have port highpassSelect, output, 3: held highpass index, 0-3; bit 2 is always 0.
REQ-009 SHALL have port cfgValid, output, 1: a configuration update request is pending to the coefficient loader.
REQ-010 SHALL have port cfgMask, output, 3: which selects changed; bit0 = freq, bit1 = lowpass, bit2 = highpass.
REQ-011 SHALL have port cfgReady, input, 1: the coefficient loader accepts the request.

Function
REQ-012 SHALL pass buttons through a 2-flop synchroniser before any other use.
REQ-013 SHALL keep a 16-bit candidate register and a debounce counter; the counter clears and candidate takes the synchronised value whenever the two differ.
REQ-014 SHALL copy candidate into a stable register when the counter reaches DEBOUNCE_CYCLES-1 with no mismatch; the counter saturates there, with no wrap.
REQ-015 SHALL treat a press as valid only when stable changes from all-zero to an exactly one-hot value; chords, and changes from any nonzero value, are ignored.
REQ-016 SHALL decode a valid press as follows: bit i in 0-7 sets freqSelect=i; bit i in 8-11 sets lowpassSelect=i-8; bit i in 12-15 sets highpassSelect=i-12.
REQ-017 SHALL update selects one clock after the stable update, giving a total latency of DEBOUNCE_CYCLES+3 rising edges from the first edge that samples the new buttons value.
REQ-018 SHALL hold selects indefinitely between valid presses; a release changes nothing.
REQ-019 SHALL, when a press selects the index already held, leave the select unchanged and set no dirty bit.
REQ-020 SHALL, when a select changes value, set the corresponding bit of a 3-bit dirty register.
REQ-021 SHALL implement handshake FSM states IDLE and REQ:
- IDLE -> REQ when dirty!=0; cfgMask loads dirty, and the loaded bits clear from dirty.
- REQ holds cfgValid=1 with cfgMask stable until cfgValid&&cfgReady.
- On acceptance: go to REQ with the new dirty if dirty!=0 (back-to-back), else to IDLE.
REQ-022 SHALL let changes arriving during REQ accumulate only in dirty, never in cfgMask.
REQ-023 SHALL apply a dirty set and a dirty capture in the same cycle so that the new bit survives.
REQ-024 SHALL drive cfgValid=0 and cfgMask=0 in IDLE.

Reset
REQ-025 SHALL on reset clear all of the following asynchronously: selects, synchroniser, candidate, stable, counter, and cfgMask.
REQ-026 SHALL on reset set dirty=3'b111, so that the first post-reset request reports all defaults to the loader.
REQ-027 SHALL on reset force the FSM to IDLE.
REQ-028 SHALL, when reset asserts mid-debounce or mid-handshake, discard the in-progress state without emitting any acceptance.

Structure
REQ-029 SHALL place the following in shared package channel_strip_pkg:
- typedef sel_t (logic [2:0]);
- constant DEBOUNCE_CYCLES_DEFAULT;
- constants for the group bit positions in cfgMask (FREQ, LOWPASS, HIGHPASS);
- the handshake FSM state enum.
REQ-030 SHALL implement the synchroniser, candidate register, counter and stable register in one sub-module, button_debounce, with a 16-bit width parameter; decode and handshake live in the top level.

Verification (bench DEBOUNCE_CYCLES=8)
REQ-031 SHALL cover reset release with cfgReady=1 -> cfgValid=1 and cfgMask=111 for one cycle, all selects 0, then cfgValid=0.
REQ-032 SHALL cover buttons=0x0020 held 20 cycles, cfgReady=1 -> freqSelect=5 exactly 11 edges after first sampling, then one request with cfgMask=001.
REQ-033 SHALL cover bit 9 toggling every 4 cycles for 40 cycles then released -> no select change, cfgValid stays 0.
REQ-034 SHALL cover buttons=0x0101 held, then a second press of 0x0020 while freqSelect=5 -> both ignored, no request.
REQ-035 SHALL cover the back-to-back handshake: cfgReady=0; press 0x2000, release, press 0x0004 -> cfgMask=100 held stable; raise cfgReady -> next request cfgMask=001; highpassSelect=1, freqSelect=2.
REQ-036 SHALL cover reset asserted 4 cycles into debounce of 0x0800 -> outputs return to reset values immediately; lowpassSelect never becomes 3.
